// File: rtl/sine_period_meter_if.sv
// Sample stream and measurement results of the sine period meter.
// The source side drives samples; the meter drives the results.
interface sine_period_meter_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 24
) ();
    logic signed [DATA_W-1:0] sine;
    logic                     sample_en;
    logic        [CNT_W-1:0]  period;
    logic signed [DATA_W-1:0] peak_max;
    logic signed [DATA_W-1:0] peak_min;
    logic                     meas_valid;
    logic                     locked;
    logic                     overflow;

    modport master (
        output sine,
        output sample_en,
        input  period,
        input  peak_max,
        input  peak_min,
        input  meas_valid,
        input  locked,
        input  overflow
    );

    modport slave (
        input  sine,
        input  sample_en,
        output period,
        output peak_max,
        output peak_min,
        output meas_valid,
        output locked,
        output overflow
    );
endinterface

// File: rtl/sine_period_meter.sv
// Period and per-cycle peak meter for a signed sample stream,
// using rising zero crossings with hysteresis.
module sine_period_meter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 24,
    parameter int HYST   = 16
) (
    input  logic               clk_100,
    input  logic               rst_n,
    sine_period_meter_if.slave m
);
    typedef enum logic [1:0] {
        SEEK_LOW,
        ARM,
        HIGH,
        LOW
    } state_t;

    localparam logic signed [DATA_W-1:0] HPOS = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HNEG = -HPOS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                   state;
    logic        [CNT_W-1:0]  cnt;
    logic signed [DATA_W-1:0] mx;
    logic signed [DATA_W-1:0] mn;
    logic        [CNT_W-1:0]  period_q;
    logic signed [DATA_W-1:0] pmax_q;
    logic signed [DATA_W-1:0] pmin_q;
    logic                     mv_q;
    logic                     lock_q;
    logic                     ovf_q;

    logic                     is_low;
    logic                     is_high;
    logic                     cnt_full;
    logic signed [DATA_W-1:0] nmx;
    logic signed [DATA_W-1:0] nmn;

    assign is_low   = (m.sine <= HNEG);
    assign is_high  = (m.sine >= HPOS);
    assign cnt_full = (cnt == CNT_MAX);

    always_comb begin
        nmx = mx;
        nmn = mn;
        if (m.sine > mx) nmx = m.sine;
        if (m.sine < mn) nmn = m.sine;
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEEK_LOW;
            cnt      <= '0;
            mx       <= '0;
            mn       <= '0;
            period_q <= '0;
            pmax_q   <= '0;
            pmin_q   <= '0;
            mv_q     <= 1'b0;
            lock_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mv_q <= 1'b0;
            if (m.sample_en) begin
                unique case (state)
                    SEEK_LOW: begin
                        if (is_low) state <= ARM;
                    end
                    ARM: begin
                        if (is_high) begin
                            cnt   <= CNT_ONE;
                            mx    <= m.sine;
                            mn    <= m.sine;
                            state <= HIGH;
                        end
                    end
                    HIGH: begin
                        // No crossing can close the window here, so a
                        // full counter always ends the measurement.
                        if (cnt_full) begin
                            ovf_q  <= 1'b1;
                            lock_q <= 1'b0;
                            state  <= SEEK_LOW;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                            mx  <= nmx;
                            mn  <= nmn;
                            if (is_low) state <= LOW;
                        end
                    end
                    LOW: begin
                        if (is_high) begin
                            period_q <= cnt;
                            pmax_q   <= mx;
                            pmin_q   <= mn;
                            mv_q     <= 1'b1;
                            lock_q   <= 1'b1;
                            cnt      <= CNT_ONE;
                            mx       <= m.sine;
                            mn       <= m.sine;
                            state    <= HIGH;
                        end else if (cnt_full) begin
                            ovf_q  <= 1'b1;
                            lock_q <= 1'b0;
                            state  <= SEEK_LOW;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                            mx  <= nmx;
                            mn  <= nmn;
                        end
                    end
                    default: state <= SEEK_LOW;
                endcase
            end
        end
    end

    assign m.period     = period_q;
    assign m.peak_max   = pmax_q;
    assign m.peak_min   = pmin_q;
    assign m.meas_valid = mv_q;
    assign m.locked     = lock_q;
    assign m.overflow   = ovf_q;
endmodule

// File: tb/tb_sine_period_meter.sv
// Bench for sine_period_meter: window-queue reference model checked
// every cycle, plus literal expectations per scenario.
module tb_sine_period_meter;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int HYST   = 16;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sine_period_meter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    sine_period_meter #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .HYST  (HYST)
    ) dut (
        .clk_100(clk),
        .rst_n  (rst_n),
        .m      (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int mv_q[$];
    int per_q[$];
    int pmax_q[$];
    int pmin_q[$];
    int tbl[64];

    // reference model state
    int phase   = 0;
    bit saw_low = 0;
    int win[$];
    int e_period = 0;
    int e_max = 0;
    int e_min = 0;
    bit e_mv = 0;
    bit e_lock = 0;
    bit e_ovf = 0;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int s);
        bit lo;
        bit hi;
        int mx;
        int mn;
        lo = (s <= -HYST);
        hi = (s >= HYST);
        if (phase == 0) begin
            if (lo) phase = 1;
        end else if (phase == 1) begin
            if (hi) begin
                win.delete();
                win.push_back(s);
                saw_low = 0;
                phase = 2;
            end
        end else begin
            if (saw_low && hi) begin
                mx = win[0];
                mn = win[0];
                foreach (win[i]) begin
                    if (win[i] > mx) mx = win[i];
                    if (win[i] < mn) mn = win[i];
                end
                e_period = win.size();
                e_max = mx;
                e_min = mn;
                e_mv = 1;
                e_lock = 1;
                win.delete();
                win.push_back(s);
                saw_low = 0;
            end else if (win.size() == MAXC) begin
                e_ovf = 1;
                e_lock = 0;
                phase = 0;
                win.delete();
            end else begin
                win.push_back(s);
                if (lo) saw_low = 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0;
            saw_low = 0;
            win.delete();
            e_period = 0;
            e_max = 0;
            e_min = 0;
            e_mv = 0;
            e_lock = 0;
            e_ovf = 0;
        end else begin
            e_mv = 0;
            if (bus.sample_en) model_step(int'(bus.sine));
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("period", bus.period, e_period);
            chk("peak_max", bus.peak_max, e_max);
            chk("peak_min", bus.peak_min, e_min);
            chk("meas_valid", bus.meas_valid, e_mv);
            chk("locked", bus.locked, e_lock);
            chk("overflow", bus.overflow, e_ovf);
            if (bus.meas_valid === 1'b1) begin
                mv_q.push_back(cyc);
                per_q.push_back(int'(bus.period));
                pmax_q.push_back(int'(bus.peak_max));
                pmin_q.push_back(int'(bus.peak_min));
            end
        end
    end

    task automatic drive(input int s, input bit en);
        @(posedge clk);
        #1;
        bus.sine = s;
        bus.sample_en = en;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0);
    endtask

    task automatic clear_log();
        mv_q.delete();
        per_q.delete();
        pmax_q.delete();
        pmin_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_period", bus.period, 0);
        chk("rst_peak_max", bus.peak_max, 0);
        chk("rst_peak_min", bus.peak_min, 0);
        chk("rst_meas_valid", bus.meas_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_overflow", bus.overflow, 0);
        bus.sine = 0;
        bus.sample_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
    endtask

    function automatic int sq(input int k);
        return ((k / 50) % 2 == 0) ? 1000 : -1000;
    endfunction

    task automatic check_square(input string nm, input int spacing);
        chk({nm, "_pulses"}, mv_q.size(), 3);
        if (mv_q.size() == 3) begin
            chk({nm, "_gap1"}, mv_q[1] - mv_q[0], spacing);
            chk({nm, "_gap2"}, mv_q[2] - mv_q[1], spacing);
            chk({nm, "_period"}, per_q[0], 100);
            chk({nm, "_max"}, pmax_q[0], 1000);
            chk({nm, "_min"}, pmin_q[0], -1000);
        end
        chk({nm, "_locked"}, bus.locked, 1);
    endtask

    initial begin
        real x;
        for (int i = 0; i < 64; i++) begin
            x = 1000.0 * $sin(2.0 * 3.14159265358979 * i / 64.0);
            tbl[i] = $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
        end
        bus.sine = 0;
        bus.sample_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset values and idle zero input
        do_reset();
        for (int i = 0; i < 100; i++) drive(0, 1);
        idle(2);
        chk("zero_no_pulse", mv_q.size(), 0);
        chk("zero_locked", bus.locked, 0);

        // basic square wave
        do_reset();
        for (int k = 0; k < 500; k++) drive(sq(k), 1);
        idle(3);
        check_square("square", 100);

        // sine stream
        do_reset();
        for (int k = 0; k < 1300; k++) drive(tbl[k % 64], 1);
        idle(3);
        chk("sine_pulses_min", int'(mv_q.size() >= 15), 1);
        foreach (per_q[i]) begin
            chk("sine_period", per_q[i], 64);
            chk("sine_sym", int'((pmax_q[i] + pmin_q[i] <= 1) &&
                                 (pmax_q[i] + pmin_q[i] >= -1)), 1);
        end
        chk("sine_overflow", bus.overflow, 0);

        // hysteresis band
        do_reset();
        for (int k = 0; k < 10000; k++) drive((k % 2 == 0) ? 10 : -10, 1);
        idle(2);
        chk("hyst_no_pulse", mv_q.size(), 0);
        for (int k = 0; k < 20; k++) drive((k % 2 == 0) ? 20 : -20, 1);
        idle(3);
        chk("hyst_pulsed", int'(mv_q.size() > 0), 1);
        if (mv_q.size() > 0) begin
            chk("hyst_period", per_q[0], 2);
            chk("hyst_max", pmax_q[0], 20);
            chk("hyst_min", pmin_q[0], -20);
        end

        // sample gating, one accepted sample in four
        do_reset();
        for (int k = 0; k < 2000; k++) drive(sq(k / 4), (k % 4) == 0);
        idle(3);
        check_square("gated", 400);

        // overflow
        do_reset();
        drive(-500, 1);
        for (int i = 1; i <= MAXC; i++) drive(500, 1);
        idle(2);
        chk("ovf_before", bus.overflow, 0);
        drive(500, 1);
        idle(2);
        chk("ovf_after", bus.overflow, 1);
        chk("ovf_locked", bus.locked, 0);
        chk("ovf_no_pulse", mv_q.size(), 0);

        // reset inside an open window, then a fresh measurement
        for (int i = 0; i < 5; i++) drive(-1000, 1);
        for (int i = 0; i < 10; i++) drive(1000, 1);
        do_reset();
        for (int k = 0; k < 500; k++) drive(sq(k), 1);
        idle(3);
        check_square("after_rst", 100);
        chk("after_rst_ovf", bus.overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
